// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH x WIDTH multiplier between two requesters.
// Optional watchdog on the RUN phase is enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   res0,
    output logic [2*WIDTH-1:0]   res1,
    output logic                 err,
    output logic                 m_opstart,
    output logic                 m_opclear,
    output logic [WIDTH-1:0]     m_multiplier,
    output logic [WIDTH-1:0]     m_multiplicand,
    input  logic                 m_done,
    input  logic [2*WIDTH-1:0]   m_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mul_arbiter: TIMEOUT must be at least 2");
    end

    state_t             state_r, state_s;
    logic               ptr_r, ptr_s;
    logic               sel_r, sel_s;
    logic               gnt0_r, gnt0_s;
    logic               gnt1_r, gnt1_s;
    logic               done0_r, done0_s;
    logic               done1_r, done1_s;
    logic               err_r, err_s;
    logic               opstart_r, opstart_s;
    logic               opclear_r, opclear_s;
    logic [WIDTH-1:0]   mplier_r, mplier_s;
    logic [WIDTH-1:0]   mcand_r, mcand_s;
    logic [2*WIDTH-1:0] res0_r, res0_s;
    logic [2*WIDTH-1:0] res1_r, res1_s;
    logic               sel_req_s;
    logic               timeout_s;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_r;

    // Watchdog: zero while in CLEAR so the first RUN cycle sees 0, then count RUN cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == CLEAR) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign timeout_s = (state_r == RUN) && (cnt_r == LAST_CNT);
`else
    assign timeout_s = 1'b0;
`endif

    assign sel_req_s = sel_r ? req1 : req0;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        sel_s     = sel_r;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        done0_s   = 1'b0;
        done1_s   = 1'b0;
        err_s     = 1'b0;
        opstart_s = 1'b0;
        opclear_s = 1'b0;
        mplier_s  = mplier_r;
        mcand_s   = mcand_r;
        res0_s    = res0_r;
        res1_s    = res1_r;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        sel_s = ptr_r;
                    end else begin
                        sel_s = req1;
                    end
                    gnt0_s    = ~sel_s;
                    gnt1_s    = sel_s;
                    opclear_s = 1'b1;
                    mplier_s  = sel_s ? a1 : a0;
                    mcand_s   = sel_s ? b1 : b0;
                    state_s   = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (!sel_req_s) begin
                    opclear_s = 1'b1;
                    ptr_s     = ~sel_r;
                    state_s   = IDLE;
                end else begin
                    gnt0_s    = ~sel_r;
                    gnt1_s    = sel_r;
                    opstart_s = 1'b1;
                    state_s   = RUN;
                end
            end
            RUN: begin
                // An abort (request withdrawn or watchdog) beats a simultaneous m_done.
                if (!sel_req_s || timeout_s) begin
                    opclear_s = 1'b1;
                    err_s     = timeout_s;
                    ptr_s     = ~sel_r;
                    state_s   = IDLE;
                end else if (m_done) begin
                    gnt0_s  = ~sel_r;
                    gnt1_s  = sel_r;
                    done0_s = ~sel_r;
                    done1_s = sel_r;
                    if (sel_r) begin
                        res1_s = m_result;
                    end else begin
                        res0_s = m_result;
                    end
                    ptr_s   = ~sel_r;
                    state_s = DONE;
                end else begin
                    gnt0_s    = ~sel_r;
                    gnt1_s    = sel_r;
                    opstart_s = 1'b1;
                    state_s   = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pointer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            ptr_r     <= 1'b0;
            sel_r     <= 1'b0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            err_r     <= 1'b0;
            opstart_r <= 1'b0;
            opclear_r <= 1'b0;
            mplier_r  <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            res0_r    <= {(2*WIDTH){1'b0}};
            res1_r    <= {(2*WIDTH){1'b0}};
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            sel_r     <= sel_s;
            gnt0_r    <= gnt0_s;
            gnt1_r    <= gnt1_s;
            done0_r   <= done0_s;
            done1_r   <= done1_s;
            err_r     <= err_s;
            opstart_r <= opstart_s;
            opclear_r <= opclear_s;
            mplier_r  <= mplier_s;
            mcand_r   <= mcand_s;
            res0_r    <= res0_s;
            res1_r    <= res1_s;
        end
    end

    assign gnt0           = gnt0_r;
    assign gnt1           = gnt1_r;
    assign done0          = done0_r;
    assign done1          = done1_r;
    assign err            = err_r;
    assign m_opstart      = opstart_r;
    assign m_opclear      = opclear_r;
    assign m_multiplier   = mplier_r;
    assign m_multiplicand = mcand_r;
    assign res0           = res0_r;
    assign res1           = res1_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed stimulus pushes expected products,
// a negedge monitor pops them on every done pulse. Honors MUL_ARB_TIMEOUT_EN.
module tb_mul_arbiter;

    localparam logic [127:0] WIDE = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;

    typedef struct {
        logic         id;
        logic [127:0] res;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          req0, req1;
    logic [63:0]   a0, b0, a1, b1;
    logic          gnt0, gnt1, done0, done1, err;
    logic [127:0]  res0, res1;
    logic          m_opstart, m_opclear;
    logic [63:0]   m_multiplier, m_multiplicand;
    logic          m_done;
    logic [127:0]  m_result;
    logic          model_done, stray_done, model_en;
    int            mcnt;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    exp_t          exp_q[$];

    assign m_done = model_done | stray_done;

    mul_arbiter #(.WIDTH(64), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1), .err(err),
        .m_opstart(m_opstart), .m_opclear(m_opclear),
        .m_multiplier(m_multiplier), .m_multiplicand(m_multiplicand),
        .m_done(m_done), .m_result(m_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit id, input int bound, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            seen = id ? done1 : done0;
        end
        check(name, {127'd0, seen}, 128'd1);
    endtask

    // Multiplier model: answers 10 cycles into m_opstart with the true product.
    initial begin
        model_done = 1'b0;
        m_result   = 128'd0;
        mcnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (m_opstart) mcnt++;
            else mcnt = 0;
            model_done = model_en && (mcnt == 10);
            if (model_done) m_result = {64'd0, m_multiplier} * {64'd0, m_multiplicand};
        end
    end

    // Monitor: every done pulse must match the oldest expected (requester, product).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done0 || done1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {126'd0, done1, done0}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_id", {126'd0, done1, done0}, e.id ? 128'd2 : 128'd1);
                    check("done_res", e.id ? res1 : res0, e.res);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int first;
        reset_n = 1'b0; req0 = 1'b1; req1 = 1'b0;
        a0 = 64'd5; b0 = 64'd4; a1 = 64'd0; b1 = 64'd0;
        model_en = 1'b1; stray_done = 1'b0;

        // Reset, single request, operand freeze
        exp_q.push_back('{1'b0, 128'd20});
        repeat (3) tick();
        check("reset_ctl", {121'd0, gnt0, gnt1, done0, done1, err, m_opstart, m_opclear}, 128'd0);
        check("reset_res", res0 | res1, 128'd0);
        check("reset_opnd", {m_multiplier, m_multiplicand}, 128'd0);
        reset_n = 1'b1;
        tick();
        check("grant0", {124'd0, gnt0, gnt1, m_opclear, m_opstart}, 128'b1010);
        check("latch", {m_multiplier, m_multiplicand}, {64'd5, 64'd4});
        tick();
        check("start", {125'd0, gnt0, m_opclear, m_opstart}, 128'b101);
        a0 = 64'd99;
        tick();
        check("freeze", {64'd0, m_multiplier}, 128'd5);
        wait_done(1'b0, 40, "done0_first");
        check("done_cycle", {126'd0, gnt0, m_opstart}, 128'b10);
        req0 = 1'b0; a0 = 64'd5;
        tick();
        check("after_done", {126'd0, gnt0, done0}, 128'd0);

        // Stray m_done in IDLE
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("stray", {122'd0, gnt0, gnt1, m_opclear, m_opstart, done0, done1}, 128'd0);
        check("stray_res", res0, 128'd20);

        // Contention from reset: expect order 0,1,0,1
        reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        a1 = 64'd7; b1 = 64'd6;
        tick(); tick();
        check("rst_clears_res", res0, 128'd0);
        exp_q.push_back('{1'b0, 128'd20});
        exp_q.push_back('{1'b1, 128'd42});
        exp_q.push_back('{1'b0, 128'd20});
        exp_q.push_back('{1'b1, 128'd42});
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && n < 4; i++) begin
            tick();
            if (done0 || done1) n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("four_ops", n, 128'd4);
        tick(); tick();

        // Full-width product, no truncation
        a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_q.push_back('{1'b1, WIDE});
        req1 = 1'b1;
        wait_done(1'b1, 40, "done1_wide");
        req1 = 1'b0;
        tick();

        // Abort of requester 1 with requester 0 pending
        a1 = 64'd7; b1 = 64'd6; req1 = 1'b1;
        tick();
        check("abort_gnt1", {126'd0, gnt0, gnt1}, 128'b01);
        tick();
        req0 = 1'b1; a0 = 64'd9; b0 = 64'd13;
        exp_q.push_back('{1'b0, 128'd117});
        tick(); tick();
        req1 = 1'b0;
        tick();
        check("abort_idle", {123'd0, gnt0, gnt1, m_opclear, m_opstart, done1}, 128'b00100);
        tick();
        check("regrant0", {125'd0, gnt0, gnt1, m_opclear}, 128'b101);
        check("res1_kept", res1, WIDE);
        wait_done(1'b0, 40, "done0_after_abort");
        req0 = 1'b0;
        tick();

        // Watchdog behaviour with a multiplier that never answers
        model_en = 1'b0; a0 = 64'd2; b0 = 64'd3; req0 = 1'b1;
        tick(); tick();
        first = 0;
`ifdef MUL_ARB_TIMEOUT_EN
        for (int i = 1; i <= 20 && first == 0; i++) begin
            tick();
            if (err) first = i;
        end
        check("timeout_cycle", first, 128'd16);
        check("timeout_abort", {124'd0, gnt0, m_opclear, m_opstart, done0}, 128'b0100);
        req0 = 1'b0;
        tick();
        check("err_pulse", {127'd0, err}, 128'd0);
`else
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (err && first == 0) first = i;
        end
        check("no_err", first, 128'd0);
        check("still_run", {125'd0, gnt0, m_opstart, m_opclear}, 128'b110);
        req0 = 1'b0;
        tick();
        check("drop_clear", {125'd0, gnt0, m_opclear, m_opstart}, 128'b010);
`endif
        tick();
        check("queue_empty", exp_q.size(), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-port arbiter and sequencer for the shared 64×64→128 multiplier. It grants the multiplier to one of two requesters (e.g. two factorial controllers) with round-robin fairness and drives the multiplier's clear/start handshake. It captures the 128-bit product into the winning requester's result register and pulses that requester's done flag. It sits between the requesters' calc blocks and the multiplier instance.

## Interface
- WIDTH, 64, operand width; products are 2*WIDTH.
- TIMEOUT, 1024, watchdog limit in cycles (used only with MUL_ARB_TIMEOUT_EN).

- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req0, req1  in  1  request; held high until the matching done pulse.
- a0, b0, a1, b1  in  WIDTH  operands (multiplier, multiplicand) for requesters 0 and 1.
- gnt0, gnt1  out  1  grant; one-hot or zero.
- done0, done1  out  1  one-cycle completion pulse.
- res0, res1  out  2*WIDTH  last product delivered to each requester.
- err  out  1  one-cycle timeout pulse; constant 0 without the macro.
- m_opstart, m_opclear  out  1  multiplier start / clear.
- m_multiplier, m_multiplicand  out  WIDTH  latched operands to the multiplier.
- m_done  in  1  multiplier completion.
- m_result  in  2*WIDTH  multiplier product.

## Operation
- The FSM has four states: IDLE, CLEAR, RUN, DONE. Reset puts it in IDLE.
- Reset values: every output is 0, res0 and res1 are 0, and the round-robin pointer selects requester 0 first.
- **IDLE**
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester the pointer favours.
  - On a grant, latch its operands into m_multiplier/m_multiplicand, set its gnt, and go to CLEAR.
- **CLEAR**
  - m_opclear=1 and m_opstart=0 for exactly one cycle, then go to RUN.
- **RUN**
  - m_opstart=1 and m_opclear=0.
  - Operands stay frozen; changes on a/b are ignored.
  - When m_done=1, capture m_result into res of the granted requester and go to DONE.
- **DONE**
  - For one cycle: the granted done pulses, m_opstart=0, and gnt stays high.
  - The pointer flips to favour the other requester.
  - Next state is IDLE, where gnt drops.
- **Abort:** if the granted req falls during CLEAR or RUN, go to IDLE next cycle.
  - No done pulse and no res update.
  - m_opclear=1 for that one IDLE cycle.
  - The pointer flips.
- The non-granted requester's req is ignored until the FSM returns to IDLE.
- m_done is ignored outside RUN.
- If m_done and an abort occur in the same RUN cycle, the abort wins: no capture.
- Result bits are passed through unmodified; there is no truncation.

## Timing
- req sampled high in IDLE at edge t → gnt and m_opclear high in cycle t+1 → m_opstart high from t+2.
- m_done sampled high at edge d → res valid and done high in cycle d+1 → gnt low at d+2 → IDLE at d+2, with a new grant visible at d+3.
- Minimum arbiter overhead per operation: 3 cycles (CLEAR, DONE, IDLE) plus the multiplier latency.
- Reset asserted mid-operation takes effect at the next edge.
  - All outputs return to 0, including m_opstart.
  - The in-flight product is discarded.

## Configuration
- MUL_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to RUN and increments every RUN cycle.
  - If the counter reaches TIMEOUT without m_done, then:
    - err pulses for one cycle;
    - the FSM aborts as above (m_opclear pulse, no done, pointer flips).
- MUL_ARB_TIMEOUT_EN undefined:
  - No counter exists and err is tied 0.
  - RUN waits indefinitely for m_done.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with req0=1 → all outputs 0. After release, gnt0 rises one cycle later, m_opclear pulses once, and m_opstart follows.
- Single request: req0 with a0=5, b0=4; model m_done 10 cycles after m_opstart, with m_result=20 → res0=20, done0 a single 1-cycle pulse, gnt0 low 2 cycles after m_done.
- Contention: req0 and req1 both high from reset → service order 0, 1, 0, 1 over four operations. res1 equals a1*b1, e.g. 7*6=42.
- Abort: drop req1 mid-RUN → next cycle IDLE with m_opclear=1, no done1, res1 unchanged, and the next grant goes to req0 if pending.
- Operand freeze and stray done: change a0 during RUN → m_multiplier unchanged. Pulse m_done in IDLE → no state change.
- Timeout (macro defined, TIMEOUT=16): never assert m_done → err pulses exactly 16 RUN cycles after entry, followed by the abort sequence. With the macro undefined, the FSM stays in RUN and err stays 0.
